// File: rtl/floating_point_unit_pkg.sv
// rtl/floating_point_unit_pkg.sv - shared FPU types, constants and rounding helper
package floating_point_unit_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exponent;
        logic [22:0] fraction;
    } float32_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } round_mode_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpu_flags_t;

    // Wide enough for biased exponents from -512 up to a post-round carry past 511.
    typedef logic signed [11:0] exp_t;

    localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;
    localparam logic [31:0] POS_INF    = 32'h7F800000;

    // Encodings 101-111 fall through to round-to-nearest-even.
    function automatic logic round_increment(input logic [2:0] rm, input logic sign,
                                             input logic lsb, input round_bits_t rb);
        logic lost;
        logic inc;
        lost = rb.guard | rb.round | rb.sticky;
        case (rm)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & lost;
            RUP:     inc = ~sign & lost;
            RMM:     inc = rb.guard;
            default: inc = rb.guard & (rb.round | rb.sticky | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/floating_point_rounder_if.sv
// rtl/floating_point_rounder_if.sv - operand/result bundle between FPU datapaths and the rounder
interface floating_point_rounder_if;
    import floating_point_unit_pkg::*;

    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic        sign_i;
    logic [9:0]  exponent_i;
    logic [24:0] significand_i;
    round_bits_t round_bits_i;
    logic [2:0]  round_mode_i;
    logic        special_i;
    logic [31:0] special_result_i;
    logic        invalid_i;
    float32_t    result_o;
    logic        valid_o;
    fpu_flags_t  flags_o;

    modport master (
        output valid_i, stall_i, flush_i, sign_i, exponent_i, significand_i,
               round_bits_i, round_mode_i, special_i, special_result_i, invalid_i,
        input  result_o, valid_o, flags_o
    );

    modport slave (
        input  valid_i, stall_i, flush_i, sign_i, exponent_i, significand_i,
               round_bits_i, round_mode_i, special_i, special_result_i, invalid_i,
        output result_o, valid_o, flags_o
    );

endinterface

// File: rtl/floating_point_rounder_count_leading_zeros.sv
// rtl/floating_point_rounder_count_leading_zeros.sv - combinational 26-bit leading-zero counter
module count_leading_zeros (
    input  logic [25:0] value_i,
    output logic [4:0]  count_o
);

    // Highest set bit is visited last, so it determines the count; all-zero gives 26.
    always_comb begin
        count_o = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (value_i[i]) count_o = 5'(25 - i);
        end
    end

endmodule

// File: rtl/floating_point_rounder.sv
// rtl/floating_point_rounder.sv - two-stage normalize/round back-end producing float32 plus flags
// FLOAT_DENORMALS_EN: generate subnormals; undefined flushes tiny results to signed zero.
module floating_point_rounder
    import floating_point_unit_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input logic                     clk_i,
    input logic                     rst_n_i,
    floating_point_rounder_if.slave bus
);

    logic [PIPE_STAGES-1:0] vld_q;

    exp_t        n_exp;
    logic [25:0] n_vec;
    logic        n_sticky;
    logic        n_tiny;
    logic        n_zero;
    exp_t        lshift;
    logic [4:0]  lzc;
    round_bits_t rb_in;
`ifdef FLOAT_DENORMALS_EN
    exp_t        dshift;
    logic [51:0] dwide;
`endif

    logic        s1_sign;
    exp_t        s1_exp;
    logic [23:0] s1_man;
    round_bits_t s1_rb;
    logic        s1_tiny;
    logic [2:0]  s1_rm;
    logic        s1_special;
    logic [31:0] s1_special_result;
    logic        s1_invalid;

    logic        inc;
    logic        to_inf;
    logic [24:0] sum;
    logic [23:0] r_man;
    exp_t        r_exp;
    float32_t    r_result;
    fpu_flags_t  r_flags;
    float32_t    res_q;
    fpu_flags_t  flags_q;

    assign rb_in = bus.round_bits_i;

    count_leading_zeros u_clz (
        .value_i ({bus.significand_i[23:0], rb_in.guard, rb_in.round}),
        .count_o (lzc)
    );

    // Stage 1: normalize into {man[23:0], G, R} with a separate sticky.
    always_comb begin
        n_exp    = {{2{bus.exponent_i[9]}}, bus.exponent_i};
        n_vec    = {bus.significand_i[23:0], rb_in.guard, rb_in.round};
        n_sticky = rb_in.sticky;
        n_tiny   = 1'b0;
        n_zero   = (bus.significand_i == '0) && (rb_in == '0);
        lshift   = '0;
`ifdef FLOAT_DENORMALS_EN
        dshift   = '0;
        dwide    = '0;
`endif
        if (bus.significand_i[24]) begin
            n_vec    = {bus.significand_i[24:1], bus.significand_i[0], rb_in.guard};
            n_sticky = rb_in.round | rb_in.sticky;
            n_exp    = n_exp + exp_t'(1);
        end else if (!bus.significand_i[23] && n_vec != '0) begin
            // Left shift stops once the exponent would drop below 1.
            if (n_exp > exp_t'(1)) begin
                lshift = (exp_t'({7'd0, lzc}) < n_exp - exp_t'(1)) ? exp_t'({7'd0, lzc})
                                                                     : n_exp - exp_t'(1);
            end
            n_vec = n_vec << lshift;
            n_exp = n_exp - lshift;
        end

        if (!n_zero && n_exp <= exp_t'(0)) begin
            n_tiny = 1'b1;
`ifdef FLOAT_DENORMALS_EN
            dshift   = (n_exp < exp_t'(-25)) ? exp_t'(26) : exp_t'(1) - n_exp;
            dwide    = {n_vec, 26'd0} >> dshift;
            n_vec    = dwide[51:26];
            n_sticky = n_sticky | (|dwide[25:0]);
`endif
            n_exp = '0;
        end else if (!n_zero && !n_vec[25]) begin
            n_tiny = 1'b1;
        end

        if (n_zero) n_exp = '0;
    end

    // Stage 2: round, then resolve overflow, tiny and bypass results.
    always_comb begin
        inc    = round_increment(s1_rm, s1_sign, s1_man[0], s1_rb);
        sum    = {1'b0, s1_man} + {24'd0, inc};
        r_man  = sum[24] ? sum[24:1] : sum[23:0];
        r_exp  = s1_exp;
        to_inf = 1'b1;
        if (sum[24]) begin
            r_exp = s1_exp + exp_t'(1);
        end else if (sum[23] && s1_exp == '0) begin
            r_exp = exp_t'(1);
        end

        r_flags          = '0;
        r_flags.invalid  = s1_invalid;
        r_flags.inexact  = s1_rb.guard | s1_rb.round | s1_rb.sticky;
        r_flags.overflow = (r_exp >= exp_t'(255));
        r_result         = {s1_sign, (r_man[23] ? r_exp[7:0] : 8'd0), r_man[22:0]};

        if (r_flags.overflow) begin
            r_flags.inexact = 1'b1;
            case (s1_rm)
                RTZ:     to_inf = 1'b0;
                RDN:     to_inf = s1_sign;
                RUP:     to_inf = ~s1_sign;
                default: to_inf = 1'b1;
            endcase
            r_result = {s1_sign, (to_inf ? POS_INF[30:0] : MAX_FINITE[30:0])};
        end

`ifdef FLOAT_DENORMALS_EN
        r_flags.underflow = s1_tiny & r_flags.inexact;
`else
        if (s1_tiny) begin
            r_result          = {s1_sign, 31'd0};
            r_flags.underflow = 1'b1;
            r_flags.inexact   = 1'b1;
        end
`endif

        if (s1_special) begin
            r_result        = s1_special_result;
            r_flags         = '0;
            r_flags.invalid = s1_invalid;
        end
    end

    // Flush beats stall on the valid bits; data registers only care about stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
        end else if (bus.flush_i) begin
            vld_q <= '0;
        end else if (!bus.stall_i) begin
            vld_q <= {vld_q[PIPE_STAGES-2:0], bus.valid_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_sign           <= 1'b0;
            s1_exp            <= '0;
            s1_man            <= '0;
            s1_rb             <= '0;
            s1_tiny           <= 1'b0;
            s1_rm             <= '0;
            s1_special        <= 1'b0;
            s1_special_result <= '0;
            s1_invalid        <= 1'b0;
            res_q             <= '0;
            flags_q           <= '0;
        end else if (!bus.stall_i) begin
            s1_sign           <= bus.sign_i;
            s1_exp            <= n_exp;
            s1_man            <= n_vec[25:2];
            s1_rb             <= {n_vec[1], n_vec[0], n_sticky};
            s1_tiny           <= n_tiny;
            s1_rm             <= bus.round_mode_i;
            s1_special        <= bus.special_i;
            s1_special_result <= bus.special_result_i;
            s1_invalid        <= bus.invalid_i;
            res_q             <= r_result;
            flags_q           <= r_flags;
        end
    end

    assign bus.valid_o  = vld_q[PIPE_STAGES-1];
    assign bus.result_o = res_q;
    assign bus.flags_o  = flags_q;

endmodule

// File: doc/floating_point_rounder.md
Name: floating_point_rounder

Overview:
- Shared normalize-and-round back-end directly downstream of the FPADD/FPMUL datapaths in the FPU.
- Consumes an unrounded sign/exponent/significand plus guard/round/sticky bits and produces a packed IEEE-754 float32_t with exception flags.
- Two-stage pipeline (normalize, round) with valid/stall/flush control.

Parameters:
- PIPE_STAGES, 2, fixed register depth; only 2 is supported.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- valid_i  in  1  input operands valid
- stall_i  in  1  freeze all pipeline registers
- flush_i  in  1  kill all in-flight operations
- sign_i  in  1  result sign
- exponent_i  in  10  signed biased exponent; may be <=0 or >=255
- significand_i  in  25  bit24 carry, bit23 hidden, bits22:0 fraction
- round_bits_i  in  3  round_bits_t {guard, round, sticky}
- round_mode_i  in  3  RISC-V rm: RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100
- special_i  in  1  bypass: output special_result_i unchanged
- special_result_i  in  32  NaN/inf/zero precomputed upstream
- invalid_i  in  1  invalid-operation flag from upstream
- result_o  out  32  float32_t result
- valid_o  out  1  result valid
- flags_o  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Interface: one clock, clk_i; asynchronous active-low reset, rst_n_i.
- Reset: valid_o=0, result_o=0, flags_o=0; internal valid bits cleared. Reset mid-operation drops all in-flight data.
- Latency: exactly 2 cycles valid_i -> valid_o with stall_i low. Throughput 1/cycle. Outputs registered.
- stall_i=1: every stage register, including outputs, holds; new inputs are ignored.
- flush_i=1: clears both stage valid bits and valid_o next edge; data registers may keep stale values. flush_i wins over stall_i.
- Stage 1, normalize; work vector N = {sig[23:0], G, R}, sticky kept separately:
  - sig[24]=1: shift right 1, exp+1; sig[0] goes to G, old G to R, old R ORed into sticky.
  - sig[24:23]=00 and sig!=0: left shift by lzc(N), limited to exp-1 so exp stays >=1; zeros shifted in.
  - Then if exp<=0: right shift by 1-exp (capped at 26), exp:=0, shifted-out bits ORed into sticky; mark tiny.
  - sig==0, G=R=S=0: exact signed zero, exp 0.
- Stage 2, round:
  - inc = RNE: G & (R|S|lsb); RTZ: 0; RDN: sign & (G|R|S); RUP: ~sign & (G|R|S); RMM: G.
  - rm 101–111 are treated as RNE.
  - Increment carry out of bit 23 increments exp. A denormal rounding into bit 23 becomes exp 1.
  - exp>=255 after rounding: overflow=1, inexact=1. Result is inf for RNE/RMM, for RUP with sign=0, and for RDN with sign=1; otherwise max finite 0x7F7FFFFF with sign.
  - inexact = G|R|S, or overflow.
  - underflow = tiny & inexact; tininess is detected before rounding.
- special_i: result_o=special_result_i; flags_o={invalid_i,0,0,0}; latency unchanged.
- invalid_i is passed to flags_o[3] on all paths.

Optional Feature:
- FLOAT_DENORMALS_EN defined: subnormal results generated as above.
- Undefined: any result tiny before rounding flushes to signed zero (0x00000000 or 0x80000000) with underflow=1, inexact=1. The denormalizing shifter is removed.

Decomposition:
- Package floating_point_unit_pkg gains:
  - round_mode_t enum (RNE, RTZ, RDN, RUP, RMM)
  - fpu_flags_t struct {invalid, overflow, underflow, inexact}
  - MAX_FINITE = 32'h7F7FFFFF
  - POS_INF = 32'h7F800000
- Reuses the existing float32_t and round_bits_t.
- One sub-module: count_leading_zeros, combinational, 26-bit input, 5-bit count output.

Test Plan:
- exp 127, sig 0x0800000, GRS 000, RNE -> 2 cycles later result 0x3F800000, flags 0000.
- exp 127, sig 0x1800000, GRS 000 -> 0x40400000 (3.0), flags 0000.
- exp 127, sig 0x0800001, GRS 100:
  - RNE -> 0x3F800002, inexact.
  - RTZ -> 0x3F800001, inexact.
- exp 254, sig 0x1FFFFFF, GRS 111:
  - RNE -> 0x7F800000, overflow+inexact.
  - RTZ -> 0x7F7FFFFF, overflow+inexact.
  - sign=1, RUP -> 0xFF7FFFFF.
- Cancellation: exp 127, sig 0x0000001, GRS 000 -> 0x34000000.
- Tiny: exp 0, sig 0x0800000, GRS 000:
  - With the macro -> 0x00400000, flags 0000.
  - Without the macro -> 0x00000000, underflow+inexact.
- Control: back-to-back valids with stall_i high for 3 cycles -> valid_o and result_o held and order preserved. Then flush_i -> valid_o=0 next cycle and no stale output.
